// File: rtl/image_write784.sv
`default_nettype none
// ============================================================================
//  Module      : image_write784
//  Description : Writer side of the 28x28 (784-byte) image buffers that the
//                VGA image draw block scans. Accepts one framed valid/ready
//                byte stream per start request, in row-major order
//                (addr = row*28 + col), and writes it into one of three image
//                RAM slots. Reports frame completion and framing errors.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLOCK_50    in   1       system clock, rising edge
//    RST         in   1       asynchronous reset, active-high
//    start       in   1       one-cycle request to receive one frame
//    slot_sel    in   2       target slot (0..2), sampled with start
//    in_data     in   8       pixel byte
//    in_valid    in   1       in_data valid
//    in_last     in   1       final byte of frame, qualified by in_valid
//    in_ready    out  1       writer accepts a byte this cycle
//    wr_address  out  ADDR_W  RAM write address, shared by all slots
//    wr_data     out  8       RAM write data
//    wr_en_0x    out  1       per-slot write strobe, at most one high
//    busy        out  1       frame in progress
//    done        out  1       pulse: full frame written
//    err_short   out  1       pulse: in_last arrived before the final byte
//    err_long    out  1       pulse: frame ran past the final byte
//    err_slot    out  1       pulse: start requested with slot_sel == 3
// ============================================================================
module image_write784 #(
    parameter int IMAGE_PIXELS = 784,
    parameter int ADDR_W       = 10
) (
    input  logic              CLOCK_50,
    input  logic              RST,
    input  logic              start,
    input  logic [1:0]        slot_sel,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ADDR_W-1:0] wr_address,
    output logic [7:0]        wr_data,
    output logic              wr_en_00,
    output logic              wr_en_01,
    output logic              wr_en_02,
    output logic              busy,
    output logic              done,
    output logic              err_short,
    output logic              err_long,
    output logic              err_slot
);

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(IMAGE_PIXELS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    logic [1:0]        r_slot;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] r_wr_address;
    logic [7:0]        r_wr_data;
    logic [2:0]        r_wr_en;
    logic              r_done;
    logic              r_err_short;
    logic              r_err_long;
    logic              r_err_slot;

    logic              w_busy;
    logic              w_beat;

    assign w_busy = (r_state != S_IDLE);
    assign w_beat = in_valid & w_busy;

    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_slot       <= 2'd0;
            r_count      <= '0;
            r_wr_address <= '0;
            r_wr_data    <= 8'd0;
            r_wr_en      <= 3'b000;
            r_done       <= 1'b0;
            r_err_short  <= 1'b0;
            r_err_long   <= 1'b0;
            r_err_slot   <= 1'b0;
        end else begin
            // Strobes and status flags are single-cycle pulses by default.
            r_wr_en     <= 3'b000;
            r_done      <= 1'b0;
            r_err_short <= 1'b0;
            r_err_long  <= 1'b0;
            r_err_slot  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (slot_sel == 2'd3) begin
                            r_err_slot <= 1'b1;
                        end else begin
                            r_slot  <= slot_sel;
                            r_count <= '0;
                            r_state <= S_RECV;
                        end
                    end
                end

                S_RECV: begin
                    if (w_beat) begin
                        r_wr_address     <= r_count;
                        r_wr_data        <= in_data;
                        r_wr_en[r_slot]  <= 1'b1;
                        if (in_last) begin
                            // Status pulse lines up with the strobe of this byte.
                            if (r_count == c_last_addr) begin
                                r_done <= 1'b1;
                            end else begin
                                r_err_short <= 1'b1;
                            end
                            r_state <= S_IDLE;
                        end else if (r_count == c_last_addr) begin
                            // Buffer full but frame not terminated: swallow the rest.
                            r_state <= S_DRAIN;
                        end else begin
                            r_count <= r_count + ADDR_W'(1);
                        end
                    end
                end

                S_DRAIN: begin
                    if (w_beat && in_last) begin
                        r_err_long <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = w_busy;
    assign busy       = w_busy;
    assign wr_address = r_wr_address;
    assign wr_data    = r_wr_data;
    assign wr_en_00   = r_wr_en[0];
    assign wr_en_01   = r_wr_en[1];
    assign wr_en_02   = r_wr_en[2];
    assign done       = r_done;
    assign err_short  = r_err_short;
    assign err_long   = r_err_long;
    assign err_slot   = r_err_slot;

endmodule
`default_nettype wire

// File: tb/tb_image_write784.sv
`default_nettype none
// ============================================================================
//  Module      : tb_image_write784
//  Description : Self-checking bench for image_write784. Stimulus pushes the
//                expected write strobes / status pulses into a queue; a
//                monitor on the falling edge pops and compares every cycle in
//                which the DUT raises a strobe or a status flag.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_image_write784;

    localparam int ADDR_W = 10;
    localparam int NPIX   = 784;

    logic              CLOCK_50;
    logic              RST;
    logic              start;
    logic [1:0]        slot_sel;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [ADDR_W-1:0] wr_address;
    logic [7:0]        wr_data;
    logic              wr_en_00;
    logic              wr_en_01;
    logic              wr_en_02;
    logic              busy;
    logic              done;
    logic              err_short;
    logic              err_long;
    logic              err_slot;

    image_write784 #(.IMAGE_PIXELS(NPIX), .ADDR_W(ADDR_W)) dut (
        .CLOCK_50   (CLOCK_50),
        .RST        (RST),
        .start      (start),
        .slot_sel   (slot_sel),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .wr_address (wr_address),
        .wr_data    (wr_data),
        .wr_en_00   (wr_en_00),
        .wr_en_01   (wr_en_01),
        .wr_en_02   (wr_en_02),
        .busy       (busy),
        .done       (done),
        .err_short  (err_short),
        .err_long   (err_long),
        .err_slot   (err_slot)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // flags = {done, err_short, err_long, err_slot}
    typedef struct {
        logic [2:0]        wen;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
        logic [3:0]        flags;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every strobe or status pulse must match the next queued entry.
    always @(negedge CLOCK_50) begin
        logic [2:0] w;
        logic [3:0] f;
        exp_t       e;
        bit         ok;
        if (!RST) begin
            w = {wr_en_02, wr_en_01, wr_en_00};
            f = {done, err_short, err_long, err_slot};
            if (w != 3'b000 || f != 4'b0000) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_output: wen=%b flags=%b addr=%0d data=%0h expected nothing",
                             w, f, wr_address, wr_data);
                end else begin
                    e  = exp_q.pop_front();
                    ok = (w == e.wen) && (f == e.flags) &&
                         ((w == 3'b000) || (wr_address == e.addr && wr_data == e.data));
                    if (!ok) begin
                        bad++;
                        $display("FAIL write_seq: got wen=%b flags=%b addr=%0d data=%0h expected wen=%b flags=%b addr=%0d data=%0h",
                                 w, f, wr_address, wr_data, e.wen, e.flags, e.addr, e.data);
                    end
                end
            end
        end
    end

    task automatic start_frame(input logic [1:0] s);
        slot_sel = s;
        start    = 1'b1;
        @(posedge CLOCK_50); #1;
        start    = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    // Send n beats with data = index; in_last on index last_at (-1 = never).
    // poke_at: index before which a stray start (slot 2) is issued mid-frame.
    task automatic send_bytes(input int n, input int last_at, input logic [1:0] slot,
                              input bit gaps, input int poke_at);
        int   waitc;
        bit   lst;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            if (i == poke_at) begin
                in_valid = 1'b0;
                slot_sel = 2'd2;
                start    = 1'b1;
                @(posedge CLOCK_50); #1;
                start    = 1'b0;
            end
            if (gaps) begin
                while ($urandom_range(0, 1) == 1) begin
                    in_valid = 1'b0;
                    @(posedge CLOCK_50); #1;
                end
            end
            waitc = 0;
            while (!in_ready && waitc < 50) begin
                @(posedge CLOCK_50); #1;
                waitc++;
            end
            if (waitc == 50) begin
                chk("ready_timeout", {31'd0, in_ready}, 32'd1);
                in_valid = 1'b0;
                return;
            end
            lst = (i == last_at);
            if (i < NPIX) begin
                e.wen   = 3'b001 << slot;
                e.addr  = ADDR_W'(i);
                e.data  = 8'(i);
                e.flags = {(lst && i == NPIX - 1), (lst && i < NPIX - 1), 2'b00};
                exp_q.push_back(e);
            end else if (lst) begin
                e.wen   = 3'b000;
                e.addr  = '0;
                e.data  = 8'd0;
                e.flags = 4'b0010;
                exp_q.push_back(e);
            end
            in_valid = 1'b1;
            in_data  = 8'(i);
            in_last  = lst;
            @(posedge CLOCK_50); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {20'd0, in_ready, busy, done, err_short, err_long, err_slot,
                   wr_en_02, wr_en_01, wr_en_00, 3'd0}, 32'd0);
        chk({name, "_addr_data"}, {14'd0, wr_address, wr_data}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        RST      = 1'b1;
        start    = 1'b0;
        slot_sel = 2'd0;
        in_data  = 8'd0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk_all_zero("reset_state");
        RST = 1'b0;
        @(posedge CLOCK_50); #1;

        // Full frame, slot 1, no gaps.
        start_frame(2'd1);
        send_bytes(NPIX, NPIX - 1, 2'd1, 1'b0, -1);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge CLOCK_50); #1;

        // Full frame, slot 1, random gaps, stray start mid-frame ignored.
        start_frame(2'd1);
        send_bytes(NPIX, NPIX - 1, 2'd1, 1'b1, 200);
        chk("busy_after_gapped", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge CLOCK_50); #1;

        // Short frame on slot 0.
        start_frame(2'd0);
        send_bytes(10, 9, 2'd0, 1'b0, -1);
        chk("busy_after_short", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge CLOCK_50); #1;
        chk("hold_addr_data", {14'd0, wr_address, wr_data}, {14'd0, 10'd9, 8'd9});

        // Long frame on slot 2.
        start_frame(2'd2);
        send_bytes(790, 789, 2'd2, 1'b0, -1);
        chk("busy_after_long", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge CLOCK_50); #1;

        // Invalid slot.
        e.wen = 3'b000; e.addr = '0; e.data = 8'd0; e.flags = 4'b0001;
        exp_q.push_back(e);
        slot_sel = 2'd3;
        start    = 1'b1;
        @(posedge CLOCK_50); #1;
        start    = 1'b0;
        chk("ready_after_bad_slot", {31'd0, in_ready}, 32'd0);
        @(posedge CLOCK_50); #1;
        chk("ready_after_bad_slot2", {31'd0, in_ready}, 32'd0);
        repeat (2) @(posedge CLOCK_50); #1;

        // Reset in the middle of a frame, then resume on slot 0.
        start_frame(2'd0);
        send_bytes(300, -1, 2'd0, 1'b0, -1);
        @(negedge CLOCK_50); #1;
        RST = 1'b1;
        @(posedge CLOCK_50); #1;
        chk_all_zero("midframe_reset");
        RST = 1'b0;
        @(posedge CLOCK_50); #1;
        start_frame(2'd0);
        send_bytes(5, 4, 2'd0, 1'b0, -1);

        repeat (5) @(posedge CLOCK_50); #1;
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
